game_flow_ctrl: RTL and testbench

- Parametrised game-flow controller for the brick-breaker top level.
- Supersedes the single-stage MENU/STAGE1/WIN/LOSE logic with N stages, configurable lives, skill-point budget with timed regeneration, pause and an inter-stage clear delay.
- Sits between the input pulse generators (start, keyboard skills) and the ball/brick/VGA/audio blocks.
- Ball and board logic hold while `freeze` is high; the brick loader reacts to `load_stage`.

---
 rtl/game_flow_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Brick-breaker game-flow controller: menu/play/pause/clear/win/lose sequencing,
// lives, skill-point budget with timed regeneration; all outputs registered.
module game_flow_ctrl #(
  parameter  int NUM_STAGES  = 3,
  parameter  int MAX_LIVES   = 5,
  parameter  int MAX_SKILL   = 3,
  parameter  int NUM_SKILLS  = 3,
  parameter  int CLEAR_TICKS = 40,
  parameter  int REGEN_TICKS = 200,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int LW = $clog2(MAX_LIVES + 1),
  localparam int PW = $clog2(MAX_SKILL + 1),
  localparam int CW = (CLEAR_TICKS > 1) ? $clog2(CLEAR_TICKS) : 1,
  localparam int RW = (REGEN_TICKS > 1) ? $clog2(REGEN_TICKS) : 1
) (
  input  logic                  clk_22,
  input  logic                  rst,
  input  logic                  start_press,
  input  logic                  pause_press,
  input  logic                  bricks_empty,
  input  logic                  ball_lost,
  input  logic [NUM_SKILLS-1:0] skill_req,
  input  logic [NUM_SKILLS-1:0] skill_active,
  output logic [2:0]            state,
  output logic [SW-1:0]         stage_idx,
  output logic [LW-1:0]         lives,
  output logic [MAX_LIVES-1:0]  life_led,
  output logic [PW-1:0]         skill_points,
  output logic [NUM_SKILLS-1:0] skill_grant,
  output logic                  load_stage,
  output logic                  freeze
);

  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_CLEAR = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [LW-1:0]         lives_q, lives_d;
  logic [PW-1:0]         points_q, points_d;
  logic [NUM_SKILLS-1:0] grant_q, grant_d;
  logic                  load_q, load_d;
  logic [CW-1:0]         clr_q, clr_d;
  logic [RW-1:0]         regen_q, regen_d;
  logic [MAX_LIVES-1:0]  led_q, led_d;
  logic                  freeze_q, freeze_d;
  logic [NUM_SKILLS-1:0] cand;
  logic                  moved, regen_wrap, do_grant;

  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      state_q  <= S_MENU;
      stage_q  <= '0;
      lives_q  <= LW'(MAX_LIVES);
      points_q <= PW'(MAX_SKILL);
      grant_q  <= '0;
      load_q   <= 1'b0;
      clr_q    <= '0;
      regen_q  <= '0;
      led_q    <= '1;
      freeze_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      lives_q  <= lives_d;
      points_q <= points_d;
      grant_q  <= grant_d;
      load_q   <= load_d;
      clr_q    <= clr_d;
      regen_q  <= regen_d;
      led_q    <= led_d;
      freeze_q <= freeze_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    lives_d    = lives_q;
    points_d   = points_q;
    clr_d      = clr_q;
    regen_d    = regen_q;
    grant_d    = '0;
    load_d     = 1'b0;
    cand       = skill_req & ~skill_active;
    moved      = 1'b0;
    regen_wrap = 1'b0;
    do_grant   = 1'b0;
    case (state_q)
      S_MENU: begin
        if (start_press) begin
          state_d  = S_PLAY;
          stage_d  = '0;
          lives_d  = LW'(MAX_LIVES);
          points_d = PW'(MAX_SKILL);
          regen_d  = '0;
          load_d   = 1'b1;
        end
      end
      S_PLAY: begin
        // The loader writes the new map during the load_stage cycle, so a stale empty flag is ignored then.
        if (bricks_empty && !load_q) begin
          moved = 1'b1;
          if (stage_q == SW'(NUM_STAGES - 1)) begin
            state_d = S_WIN;
          end else begin
            state_d = S_CLEAR;
            clr_d   = CW'(CLEAR_TICKS - 1);
          end
        end else if (ball_lost) begin
          if (lives_q == LW'(1)) begin
            moved   = 1'b1;
            state_d = S_LOSE;
            lives_d = '0;
          end else begin
            lives_d = lives_q - LW'(1);
          end
        end else if (pause_press) begin
          moved   = 1'b1;
          state_d = S_PAUSE;
        end
        if (REGEN_TICKS > 0) begin
          if (regen_q == RW'(REGEN_TICKS - 1)) begin
            regen_wrap = 1'b1;
            regen_d    = '0;
          end else begin
            regen_d = regen_q + RW'(1);
          end
        end
        do_grant = !moved && (points_q != '0) && (cand != '0);
        if (do_grant) grant_d = cand & (~cand + NUM_SKILLS'(1));
        if (do_grant && !regen_wrap) begin
          points_d = points_q - PW'(1);
        end else if (!do_grant && regen_wrap && (points_q != PW'(MAX_SKILL))) begin
          points_d = points_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (pause_press) state_d = S_PLAY;
      end
      S_CLEAR: begin
        if (clr_q == '0) begin
          state_d = S_PLAY;
          stage_d = stage_q + SW'(1);
          load_d  = 1'b1;
          regen_d = '0;
        end else begin
          clr_d = clr_q - CW'(1);
        end
      end
      S_WIN, S_LOSE: begin
        if (start_press) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase
  end

  // Derived outputs come from next-state values so they register alongside state/lives.
  always_comb begin
    freeze_d = (state_d != S_PLAY);
    for (int i = 0; i < MAX_LIVES; i++) led_d[i] = (int'(lives_d) > i);
  end

  assign state        = state_q;
  assign stage_idx    = stage_q;
  assign lives        = lives_q;
  assign life_led     = led_q;
  assign skill_points = points_q;
  assign skill_grant  = grant_q;
  assign load_stage   = load_q;
  assign freeze       = freeze_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: vector table plus multi-cycle sequences,
// expectations queued at drive time and compared after the clock edge.
module tb_game_flow_ctrl;

  logic       clk_22 = 1'b0;
  logic       rst;
  logic       start_press, pause_press, bricks_empty, ball_lost;
  logic [2:0] skill_req, skill_active;
  logic [2:0] state;
  logic [1:0] stage_idx;
  logic [2:0] lives;
  logic [4:0] life_led;
  logic [1:0] skill_points;
  logic [2:0] skill_grant;
  logic       load_stage, freeze;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_22 = ~clk_22;

  game_flow_ctrl dut (
    .clk_22(clk_22), .rst(rst),
    .start_press(start_press), .pause_press(pause_press),
    .bricks_empty(bricks_empty), .ball_lost(ball_lost),
    .skill_req(skill_req), .skill_active(skill_active),
    .state(state), .stage_idx(stage_idx), .lives(lives), .life_led(life_led),
    .skill_points(skill_points), .skill_grant(skill_grant),
    .load_stage(load_stage), .freeze(freeze)
  );

  typedef struct {
    string      nm;
    logic       st, pa, be, bl;
    logic [2:0] req, act;
    logic [2:0] s;
    logic [1:0] sg;
    logic [2:0] lv;
    logic [4:0] led;
    logic [1:0] p;
    logic [2:0] g;
    logic       ld, fz;
  } vec_t;

  typedef struct {
    string      nm;
    logic [2:0] s;
    logic [1:0] sg;
    logic [2:0] lv;
    logic [4:0] led;
    logic [1:0] p;
    logic [2:0] g;
    logic       ld, fz;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  task automatic add(string nm, logic st, logic pa, logic be, logic bl, logic [2:0] req,
                     logic [2:0] act, logic [2:0] s, logic [1:0] sg, logic [2:0] lv,
                     logic [4:0] led, logic [1:0] p, logic [2:0] g, logic ld, logic fz);
    vec_t v;
    v.nm = nm; v.st = st; v.pa = pa; v.be = be; v.bl = bl; v.req = req; v.act = act;
    v.s = s; v.sg = sg; v.lv = lv; v.led = led; v.p = p; v.g = g; v.ld = ld; v.fz = fz;
    tbl.push_back(v);
  endtask

  task automatic drive(logic st, logic pa, logic be, logic bl, logic [2:0] req, logic [2:0] act);
    start_press = st; pause_press = pa; bricks_empty = be; ball_lost = bl;
    skill_req = req; skill_active = act;
  endtask

  task automatic expect_o(string nm, logic [2:0] s, logic [1:0] sg, logic [2:0] lv,
                          logic [4:0] led, logic [1:0] p, logic [2:0] g, logic ld, logic fz);
    exp_t e;
    e.nm = nm; e.s = s; e.sg = sg; e.lv = lv; e.led = led; e.p = p; e.g = g; e.ld = ld; e.fz = fz;
    sb_q.push_back(e);
  endtask

  task automatic compare_o();
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: got no queued expectation, want one");
      return;
    end
    e = sb_q.pop_front();
    if (state !== e.s || stage_idx !== e.sg || lives !== e.lv || life_led !== e.led ||
        skill_points !== e.p || skill_grant !== e.g || load_stage !== e.ld || freeze !== e.fz) begin
      n_bad++;
      $display("FAIL %s: got st=%0d stg=%0d lv=%0d led=%b pts=%0d gnt=%b ld=%b frz=%b ; want st=%0d stg=%0d lv=%0d led=%b pts=%0d gnt=%b ld=%b frz=%b",
               e.nm, state, stage_idx, lives, life_led, skill_points, skill_grant, load_stage, freeze,
               e.s, e.sg, e.lv, e.led, e.p, e.g, e.ld, e.fz);
    end
  endtask

  task automatic tick();
    @(posedge clk_22);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cyc(string nm, logic st, logic pa, logic be, logic bl, logic [2:0] req,
                     logic [2:0] act, logic [2:0] s, logic [1:0] sg, logic [2:0] lv,
                     logic [4:0] led, logic [1:0] p, logic [2:0] g, logic ld, logic fz);
    drive(st, pa, be, bl, req, act);
    expect_o(nm, s, sg, lv, led, p, g, ld, fz);
    tick();
    compare_o();
    drive(0, 0, 0, 0, 3'd0, 3'd0);
  endtask

  initial begin
    logic [2:0] lv_m;
    logic [4:0] all_on;
    rst = 1'b1;
    drive(0, 0, 0, 0, 3'd0, 3'd0);
    all_on = 5'h1F;

    // Stimulus table: start, skills, pause, and the lives run-down to LOSE.
    add("idle_menu",     0,0,0,0, 3'd0,3'd0, 3'd0,2'd0,3'd5,5'h1F,2'd3,3'b000,0,1);
    add("start",         1,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd3,3'b000,1,0);
    add("be_in_load",    0,0,1,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd3,3'b000,0,0);
    add("skill_all",     0,0,0,0, 3'd7,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd2,3'b001,0,0);
    add("skill_busy",    0,0,0,0, 3'd1,3'd1, 3'd1,2'd0,3'd5,5'h1F,2'd2,3'b000,0,0);
    add("skill_masked",  0,0,0,0, 3'd3,3'd1, 3'd1,2'd0,3'd5,5'h1F,2'd1,3'b010,0,0);
    add("skill_last",    0,0,0,0, 3'd4,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd0,3'b100,0,0);
    add("skill_empty",   0,0,0,0, 3'd7,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd0,3'b000,0,0);
    add("start_in_play", 1,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd0,3'b000,0,0);
    add("pause_on",      0,1,0,0, 3'd0,3'd0, 3'd2,2'd0,3'd5,5'h1F,2'd0,3'b000,0,1);
    add("pause_ignore",  0,0,1,1, 3'd7,3'd0, 3'd2,2'd0,3'd5,5'h1F,2'd0,3'b000,0,1);
    add("pause_off",     0,1,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd0,3'b000,0,0);
    for (int k = 1; k <= 4; k++) begin
      lv_m = 3'(5 - k);
      add("ball_lost", 0,0,0,1, 3'd0,3'd0, 3'd1,2'd0,lv_m,all_on >> (5 - k + 0) >> 0 >> k, 2'd0,3'b000,0,0);
      tbl[tbl.size()-1].led = all_on >> k;
      add("lost_gap",  0,0,0,0, 3'd0,3'd0, 3'd1,2'd0,lv_m,all_on >> k,2'd0,3'b000,0,0);
      add("lost_gap",  0,0,0,0, 3'd0,3'd0, 3'd1,2'd0,lv_m,all_on >> k,2'd0,3'b000,0,0);
    end
    add("last_life",     0,0,0,1, 3'd0,3'd0, 3'd5,2'd0,3'd0,5'h00,2'd0,3'b000,0,1);
    add("lose_ignore",   0,1,1,1, 3'd7,3'd0, 3'd5,2'd0,3'd0,5'h00,2'd0,3'b000,0,1);
    add("lose_to_menu",  1,0,0,0, 3'd0,3'd0, 3'd0,2'd0,3'd0,5'h00,2'd0,3'b000,0,1);

    tick();
    cyc("reset_state", 1,1,1,1, 3'd7,3'd0, 3'd0,2'd0,3'd5,5'h1F,2'd3,3'b000,0,1);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].nm, tbl[i].st, tbl[i].pa, tbl[i].be, tbl[i].bl, tbl[i].req, tbl[i].act,
          tbl[i].s, tbl[i].sg, tbl[i].lv, tbl[i].led, tbl[i].p, tbl[i].g, tbl[i].ld, tbl[i].fz);

    // Regeneration: drain points, then 200 PLAY cycles give one point back.
    cyc("restart",     1,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd3,3'b000,1,0);
    cyc("drain_a",     0,0,0,0, 3'd1,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd2,3'b001,0,0);
    cyc("drain_b",     0,0,0,0, 3'd2,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd1,3'b010,0,0);
    cyc("drain_c",     0,0,0,0, 3'd4,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd0,3'b100,0,0);
    idle(195);
    cyc("regen_pre",   0,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd0,3'b000,0,0);
    cyc("regen_200",   0,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd1,3'b000,0,0);

    // 150 PLAY + 50 PAUSE + 50 PLAY cycles; grant lands on the wrap cycle.
    idle(149);
    cyc("rg_pause_on", 0,1,0,0, 3'd0,3'd0, 3'd2,2'd0,3'd5,5'h1F,2'd1,3'b000,0,1);
    idle(49);
    cyc("rg_pause_off",0,1,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd1,3'b000,0,0);
    idle(48);
    cyc("regen_pre2",  0,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd1,3'b000,0,0);
    cyc("grant_regen", 0,0,0,0, 3'd1,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd1,3'b001,0,0);
    cyc("grant_once",  0,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd1,3'b000,0,0);

    // Stage progression with 40-cycle clears, then WIN.
    cyc("be_bl_req",   0,0,1,1, 3'd1,3'd0, 3'd3,2'd0,3'd5,5'h1F,2'd1,3'b000,0,1);
    idle(38);
    cyc("clear_hold",  1,1,1,1, 3'd7,3'd0, 3'd3,2'd0,3'd5,5'h1F,2'd1,3'b000,0,1);
    cyc("clear_done",  0,0,0,0, 3'd0,3'd0, 3'd1,2'd1,3'd5,5'h1F,2'd1,3'b000,1,0);
    cyc("s1_load_be",  0,0,1,0, 3'd0,3'd0, 3'd1,2'd1,3'd5,5'h1F,2'd1,3'b000,0,0);
    cyc("be_s1",       0,0,1,0, 3'd0,3'd0, 3'd3,2'd1,3'd5,5'h1F,2'd1,3'b000,0,1);
    idle(39);
    cyc("clear2_done", 0,0,0,0, 3'd0,3'd0, 3'd1,2'd2,3'd5,5'h1F,2'd1,3'b000,1,0);
    cyc("s2_load_be",  0,0,1,0, 3'd0,3'd0, 3'd1,2'd2,3'd5,5'h1F,2'd1,3'b000,0,0);
    cyc("be_s2_win",   0,0,1,0, 3'd0,3'd0, 3'd4,2'd2,3'd5,5'h1F,2'd1,3'b000,0,1);
    cyc("win_ignore",  0,1,1,1, 3'd7,3'd0, 3'd4,2'd2,3'd5,5'h1F,2'd1,3'b000,0,1);
    cyc("win_menu",    1,0,0,0, 3'd0,3'd0, 3'd0,2'd2,3'd5,5'h1F,2'd1,3'b000,0,1);

    // Reset asserted during CLEAR takes effect without a clock edge.
    cyc("restart2",    1,0,0,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd3,3'b000,1,0);
    cyc("s0_load_be",  0,0,1,0, 3'd0,3'd0, 3'd1,2'd0,3'd5,5'h1F,2'd3,3'b000,0,0);
    cyc("be_s0_clear", 0,0,1,0, 3'd0,3'd0, 3'd3,2'd0,3'd5,5'h1F,2'd3,3'b000,0,1);
    idle(5);
    rst = 1'b1;
    #2;
    expect_o("rst_async", 3'd0,2'd0,3'd5,5'h1F,2'd3,3'b000,0,1);
    compare_o();
    cyc("rst_hold",    1,0,1,0, 3'd0,3'd0, 3'd0,2'd0,3'd5,5'h1F,2'd3,3'b000,0,1);
    rst = 1'b0;
    cyc("post_rst",    0,0,0,0, 3'd0,3'd0, 3'd0,2'd0,3'd5,5'h1F,2'd3,3'b000,0,1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
